// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and FSM encoding for the programmable clock divider
package clk_div_pkg;
   localparam int CNT_W_DEF = 8;
   localparam int MIN_DIV = 2;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/clk_div_half_phase.sv
// clk_div_half_phase: negedge half-cycle extension flop and the glitch-free output OR
module clk_div_half_phase (
   input  logic clk_in,
   input  logic rst_n,
   input  logic pos_q,
   input  logic odd,
   output logic clk_out
);
   logic neg_q;
   always_ff @(negedge clk_in or negedge rst_n)
      if (!rst_n) neg_q <= 1'b0;
      else neg_q <= pos_q;
   // odd only changes at a wrap edge, where neg_q is already low
   assign clk_out = pos_q | (odd & neg_q);
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable 50%-duty integer clock divider with boundary-only reload
module clk_div_prog import clk_div_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             clk_out,
   output logic             period_tick,
   output logic [CNT_W-1:0] div_active,
   output logic             load_ack,
   output logic             load_err
);
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, pend, pend_nx, div_nx, half;
   logic pos_q, pos_nx, tick_nx, pend_vld, pend_vld_nx, ack_nx, load_ok, apply;
   assign half = div_active >> 1;
   assign load_ok = div_load && (div_val >= CNT_W'(MIN_DIV));
   // every IDLE edge is a period boundary, as is the wrap from N-1 back to 0
   assign apply = (state == IDLE) || (cnt == div_active - CNT_W'(1));
   always_comb begin
      state_nx = state;
      cnt_nx = cnt + CNT_W'(1);
      pos_nx = (cnt + CNT_W'(1)) < half;
      tick_nx = 1'b0;
      div_nx = div_active;
      pend_nx = load_ok ? div_val : pend;
      pend_vld_nx = pend_vld | load_ok;
      ack_nx = 1'b0;
      if (apply) begin
         div_nx = load_ok ? div_val : pend_vld ? pend : div_active;
         ack_nx = load_ok | pend_vld;
         pend_nx = pend;
         pend_vld_nx = 1'b0;
         state_nx = en ? RUN : IDLE;
         cnt_nx = '0;
         pos_nx = en;
         tick_nx = en;
      end
   end
   always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         pos_q <= 1'b0;
         period_tick <= 1'b0;
         div_active <= CNT_W'(DEFAULT_DIV);
         pend <= '0;
         pend_vld <= 1'b0;
         load_ack <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         pos_q <= pos_nx;
         period_tick <= tick_nx;
         div_active <= div_nx;
         pend <= pend_nx;
         pend_vld <= pend_vld_nx;
         load_ack <= ack_nx;
         load_err <= div_load & ~load_ok;
      end
   clk_div_half_phase u_half (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .pos_q  (pos_q),
      .odd    (div_active[0]),
      .clk_out(clk_out)
   );
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed timing scenarios plus randomized run against a period-level model
`timescale 1ns/1ps
module tb_clk_div_prog;
   import clk_div_pkg::*;
   localparam int W = 8;
   logic clk_in = 1'b0, rst_n = 1'b0, en = 1'b0, div_load = 1'b0;
   logic [W-1:0] div_val = '0;
   logic clk_out, period_tick, load_ack, load_err;
   logic [W-1:0] div_active;
   int checks = 0, failures = 0;
   int rise_cnt = 0, fall_cnt = 0, ack_cnt = 0, cnt_max = 0;
   time last_rise = 0, prev_rise = 0, last_fall = 0;
   bit saw5 = 1'b0;

   clk_div_prog #(.CNT_W(W), .DEFAULT_DIV(3)) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .en         (en),
      .div_val    (div_val),
      .div_load   (div_load),
      .clk_out    (clk_out),
      .period_tick(period_tick),
      .div_active (div_active),
      .load_ack   (load_ack),
      .load_err   (load_err)
   );

   always #10 clk_in = ~clk_in;
   always @(posedge clk_out) begin
      prev_rise = last_rise;
      last_rise = $time;
      rise_cnt++;
   end
   always @(negedge clk_out) begin
      last_fall = $time;
      fall_cnt++;
   end
   always @(negedge clk_in) begin
      if (load_ack === 1'b1) ack_cnt++;
      if (div_active === 8'd5) saw5 = 1'b1;
      if (int'(dut.cnt) > cnt_max) cnt_max = int'(dut.cnt);
   end

   task automatic wait_evt(input bit fall, input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk_in); #1;
         ok = fall ? (fall_cnt >= target) : (rise_cnt >= target);
      end
   endtask

   task automatic sync_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(posedge clk_in); #1;
         ok = (period_tick === 1'b1);
      end
   endtask

   task automatic load_pulse(input int v);
      @(negedge clk_in);
      div_load = 1'b1;
      div_val = W'(v);
      @(negedge clk_in);
      div_load = 1'b0;
   endtask

   task automatic test_reset;
      en = 1'b1; div_load = 1'b0; rst_n = 1'b0;
      #25;
      checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
      checks++; if (period_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", period_tick); end
      checks++; if (div_active !== 8'd3) begin failures++; $display("FAIL reset_div got=%0d exp=3", div_active); end
      checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", load_ack); end
      checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", load_err); end
      @(negedge clk_in) rst_n = 1'b1;
      @(posedge clk_in); #1;
      checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL first_edge_clk got=%b exp=1", clk_out); end
      checks++; if (period_tick !== 1'b1) begin failures++; $display("FAIL first_edge_tick got=%b exp=1", period_tick); end
   endtask

   task automatic test_defaults;
      int b, ticks;
      bit ok;
      b = rise_cnt;
      wait_evt(1'b0, b + 3, 50, ok);
      checks++; if (!ok) begin failures++; $display("FAIL def_timeout got=%0d exp=%0d rises", rise_cnt, b + 3); end
      checks++; if (last_rise - prev_rise != 60) begin failures++; $display("FAIL def_period got=%0d exp=60", last_rise - prev_rise); end
      checks++; if (last_fall - prev_rise != 30) begin failures++; $display("FAIL def_high got=%0d exp=30", last_fall - prev_rise); end
      ticks = 0;
      repeat (9) begin @(posedge clk_in); #1; if (period_tick === 1'b1) ticks++; end
      checks++; if (ticks != 3) begin failures++; $display("FAIL def_ticks got=%0d exp=3", ticks); end
      checks++; if (div_active !== 8'd3) begin failures++; $display("FAIL def_div got=%0d exp=3", div_active); end
   endtask

   task automatic test_reload4;
      int b, a0;
      bit ok;
      sync_tick(ok);
      checks++; if (!ok) begin failures++; $display("FAIL r4_sync got=0 exp=1"); end
      b = rise_cnt; a0 = ack_cnt;
      load_pulse(4);
      wait_evt(1'b0, b + 1, 100, ok);
      checks++; if (last_rise - prev_rise != 60) begin failures++; $display("FAIL r4_old_period got=%0d exp=60", last_rise - prev_rise); end
      wait_evt(1'b0, b + 2, 100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL r4_timeout got=%0d exp=%0d rises", rise_cnt, b + 2); end
      checks++; if (last_rise - prev_rise != 80) begin failures++; $display("FAIL r4_period got=%0d exp=80", last_rise - prev_rise); end
      checks++; if (last_fall - prev_rise != 40) begin failures++; $display("FAIL r4_high got=%0d exp=40", last_fall - prev_rise); end
      checks++; if (ack_cnt - a0 != 1) begin failures++; $display("FAIL r4_acks got=%0d exp=1", ack_cnt - a0); end
      checks++; if (div_active !== 8'd4) begin failures++; $display("FAIL r4_div got=%0d exp=4", div_active); end
   endtask

   task automatic test_double_load;
      int b, a0;
      bit ok;
      sync_tick(ok);
      b = rise_cnt; a0 = ack_cnt; saw5 = 1'b0;
      load_pulse(5);
      load_pulse(7);
      wait_evt(1'b0, b + 1, 100, ok);
      checks++; if (last_rise - prev_rise != 80) begin failures++; $display("FAIL dl_old_period got=%0d exp=80", last_rise - prev_rise); end
      wait_evt(1'b0, b + 2, 100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL dl_timeout got=%0d exp=%0d rises", rise_cnt, b + 2); end
      checks++; if (last_rise - prev_rise != 140) begin failures++; $display("FAIL dl_period got=%0d exp=140", last_rise - prev_rise); end
      checks++; if (last_fall - prev_rise != 70) begin failures++; $display("FAIL dl_high got=%0d exp=70", last_fall - prev_rise); end
      checks++; if (div_active !== 8'd7) begin failures++; $display("FAIL dl_div got=%0d exp=7", div_active); end
      checks++; if (ack_cnt - a0 != 1) begin failures++; $display("FAIL dl_acks got=%0d exp=1", ack_cnt - a0); end
      checks++; if (saw5) begin failures++; $display("FAIL dl_saw5 got=1 exp=0"); end
   endtask

   task automatic test_wrap_load;
      int b;
      bit ok;
      sync_tick(ok);
      repeat (6) @(posedge clk_in);
      @(negedge clk_in);
      div_load = 1'b1; div_val = 8'd6;
      @(posedge clk_in); #1;
      div_load = 1'b0;
      checks++; if (period_tick !== 1'b1) begin failures++; $display("FAIL wl_tick got=%b exp=1", period_tick); end
      checks++; if (div_active !== 8'd6) begin failures++; $display("FAIL wl_div got=%0d exp=6", div_active); end
      b = rise_cnt;
      wait_evt(1'b0, b + 1, 100, ok);
      checks++; if (last_rise - prev_rise != 120) begin failures++; $display("FAIL wl_period got=%0d exp=120", last_rise - prev_rise); end
      checks++; if (last_fall - prev_rise != 60) begin failures++; $display("FAIL wl_high got=%0d exp=60", last_fall - prev_rise); end
   endtask

   task automatic test_load_err;
      int a0;
      a0 = ack_cnt;
      @(negedge clk_in); div_load = 1'b1; div_val = 8'd1;
      @(posedge clk_in); #1;
      checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL err1 got=%b exp=1", load_err); end
      @(negedge clk_in); div_val = 8'd0;
      @(posedge clk_in); #1;
      checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL err0 got=%b exp=1", load_err); end
      @(negedge clk_in); div_load = 1'b0;
      @(posedge clk_in); #1;
      checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", load_err); end
      repeat (20) @(posedge clk_in); #1;
      checks++; if (div_active !== 8'd6) begin failures++; $display("FAIL err_div got=%0d exp=6", div_active); end
      checks++; if (ack_cnt != a0) begin failures++; $display("FAIL err_acks got=%0d exp=%0d", ack_cnt, a0); end
   endtask

   task automatic test_max_stop;
      int b, f0;
      bit ok;
      b = rise_cnt;
      load_pulse(255);
      cnt_max = 0;
      wait_evt(1'b0, b + 2, 600, ok);
      checks++; if (!ok) begin failures++; $display("FAIL max_timeout got=%0d exp=%0d rises", rise_cnt, b + 2); end
      checks++; if (last_rise - prev_rise != 5100) begin failures++; $display("FAIL max_period got=%0d exp=5100", last_rise - prev_rise); end
      checks++; if (last_fall - prev_rise != 2550) begin failures++; $display("FAIL max_high got=%0d exp=2550", last_fall - prev_rise); end
      checks++; if (cnt_max != 254) begin failures++; $display("FAIL max_cnt got=%0d exp=254", cnt_max); end
      b = rise_cnt;
      repeat (10) @(negedge clk_in);
      en = 1'b0;
      f0 = fall_cnt;
      wait_evt(1'b1, f0 + 1, 300, ok);
      checks++; if (last_fall - last_rise != 2550) begin failures++; $display("FAIL stop_high got=%0d exp=2550", last_fall - last_rise); end
      repeat (100) @(negedge clk_in);
      checks++; if (dut.state !== RUN) begin failures++; $display("FAIL stop_midrun got=%b exp=%b", dut.state, RUN); end
      repeat (200) @(negedge clk_in);
      checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL stop_idle got=%b exp=%b", dut.state, IDLE); end
      checks++; if (rise_cnt != b || clk_out !== 1'b0) begin failures++; $display("FAIL stop_quiet got=%0d/%b exp=%0d/0", rise_cnt, clk_out, b); end
      en = 1'b1;
      wait_evt(1'b0, b + 1, 10, ok);
      checks++; if (!ok) begin failures++; $display("FAIL restart_rise got=%0d exp=%0d", rise_cnt, b + 1); end
      f0 = fall_cnt;
      wait_evt(1'b1, f0 + 1, 300, ok);
      checks++; if (last_fall - last_rise != 2550) begin failures++; $display("FAIL restart_high got=%0d exp=2550", last_fall - last_rise); end
   endtask

   task automatic test_async_reset;
      int b, r0;
      bit ok;
      b = rise_cnt;
      load_pulse(3);
      wait_evt(1'b0, b + 2, 600, ok);
      checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL ar_pre got=%b exp=1", clk_out); end
      rst_n = 1'b0;
      en = 1'b0;
      #1;
      checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL ar_clk got=%b exp=0", clk_out); end
      checks++; if (div_active !== 8'd3) begin failures++; $display("FAIL ar_div got=%0d exp=3", div_active); end
      checks++; if (dut.pend_vld !== 1'b0) begin failures++; $display("FAIL ar_pend got=%b exp=0", dut.pend_vld); end
      @(negedge clk_in) rst_n = 1'b1;
      r0 = rise_cnt;
      repeat (10) @(posedge clk_in); #1;
      checks++; if (rise_cnt != r0 || clk_out !== 1'b0) begin failures++; $display("FAIL ar_quiet got=%0d/%b exp=%0d/0", rise_cnt, clk_out, r0); end
   endtask

   task automatic test_random;
      int m_div, m_pend, m_pos, half;
      bit m_pv, m_run, bnd, good, e_ack, e_err, e_tick, e_clk;
      rst_n = 1'b0; div_load = 1'b0; en = 1'(($urandom & 1));
      #25;
      @(negedge clk_in) rst_n = 1'b1;
      m_div = 3; m_pend = 0; m_pos = 0; m_pv = 1'b0; m_run = 1'b0;
      for (int c = 0; c < 800; c++) begin
         en = ($urandom_range(0, 7) != 0);
         div_load = ($urandom_range(0, 7) == 0);
         div_val = W'($urandom_range(0, 9));
         @(posedge clk_in);
         bnd = !m_run || (m_pos == m_div - 1);
         good = div_load && div_val >= 2;
         e_err = div_load && !good;
         e_ack = bnd && (good || m_pv);
         if (bnd) begin
            if (good) m_div = int'(div_val);
            else if (m_pv) m_div = m_pend;
            m_pv = 1'b0;
            m_run = en;
            m_pos = 0;
         end else begin
            if (good) begin m_pend = int'(div_val); m_pv = 1'b1; end
            m_pos++;
         end
         half = m_div / 2;
         e_tick = m_run && m_pos == 0;
         e_clk = m_run && (m_pos < half || (m_div % 2 == 1 && m_pos == half));
         #1;
         checks++; if (period_tick !== e_tick) begin failures++; $display("FAIL rnd_tick c=%0d got=%b exp=%b", c, period_tick, e_tick); end
         checks++; if (clk_out !== e_clk) begin failures++; $display("FAIL rnd_clk_pos c=%0d got=%b exp=%b", c, clk_out, e_clk); end
         checks++; if (div_active !== W'(m_div)) begin failures++; $display("FAIL rnd_div c=%0d got=%0d exp=%0d", c, div_active, m_div); end
         checks++; if (load_ack !== e_ack) begin failures++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, load_ack, e_ack); end
         checks++; if (load_err !== e_err) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, load_err, e_err); end
         @(negedge clk_in); #1;
         e_clk = m_run && m_pos < half;
         checks++; if (clk_out !== e_clk) begin failures++; $display("FAIL rnd_clk_neg c=%0d got=%b exp=%b", c, clk_out, e_clk); end
      end
      div_load = 1'b0;
   endtask

   initial begin
      test_reset;
      test_defaults;
      test_reload4;
      test_double_load;
      test_wrap_load;
      test_load_err;
      test_max_stop;
      test_async_reset;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
